// File: rtl/layer_fetch_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_fetch_scheduler_if
// Brief    : Handshake/bus bundle between the layer fetch scheduler and its
//            window slider, shared weight memory and calculator unit.
// Revision : 1.0
// ============================================================================
interface layer_fetch_scheduler_if #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int IDX_WIDTH      = 10
);
    logic                      start;
    logic                      win_valid;
    logic                      slide;
    logic                      mem_ren;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      calc_ready;
    logic                      row_valid;
    logic [1:0]                row_layer;
    logic [IDX_WIDTH-1:0]      row_idx;
    logic                      calc_layer_done;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        input  start, win_valid, calc_ready, calc_layer_done,
        output slide, mem_ren, mem_addr, row_valid, row_layer, row_idx,
               busy, done, err
    );

    modport slave (
        output start, win_valid, calc_ready, calc_layer_done,
        input  slide, mem_ren, mem_addr, row_valid, row_layer, row_idx,
               busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/layer_fetch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : layer_fetch_scheduler
// Brief    : Runs L1->L2->L3 weight fetches per image window over a shared
//            memory; optional perf counters under SCHED_PERF_CNT_EN.
// Revision : 1.0
// ============================================================================
module layer_fetch_scheduler #(
    parameter int NUM_NEURONS_L1 = 1024,
    parameter int NUM_NEURONS_L2 = 64,
    parameter int NUM_NEURONS_L3 = 10,
    parameter int NUM_WINDOWS    = 900,
    parameter int RD_LATENCY     = 1,
    parameter int MEM_ADDR_WIDTH = $clog2(NUM_NEURONS_L1 + NUM_NEURONS_L2 + NUM_NEURONS_L3),
    parameter int IDX_WIDTH      = $clog2(NUM_NEURONS_L1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    layer_fetch_scheduler_if.master   bus
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               busy_cycles
`endif
);
    localparam int CNT_WIDTH = $clog2(NUM_WINDOWS + 1);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_wait_win  = 3'd1;
    localparam logic [2:0] c_st_fetch     = 3'd2;
    localparam logic [2:0] c_st_drain     = 3'd3;
    localparam logic [2:0] c_st_wait_calc = 3'd4;
    localparam logic [2:0] c_st_next_win  = 3'd5;

    localparam logic [MEM_ADDR_WIDTH-1:0] c_base_l2 = MEM_ADDR_WIDTH'(NUM_NEURONS_L1);
    localparam logic [MEM_ADDR_WIDTH-1:0] c_base_l3 = MEM_ADDR_WIDTH'(NUM_NEURONS_L1 + NUM_NEURONS_L2);
    localparam logic [IDX_WIDTH-1:0]      c_last_l1 = IDX_WIDTH'(NUM_NEURONS_L1 - 1);
    localparam logic [IDX_WIDTH-1:0]      c_last_l2 = IDX_WIDTH'(NUM_NEURONS_L2 - 1);
    localparam logic [IDX_WIDTH-1:0]      c_last_l3 = IDX_WIDTH'(NUM_NEURONS_L3 - 1);
    localparam logic [CNT_WIDTH-1:0]      c_num_win = CNT_WIDTH'(NUM_WINDOWS);

    logic [2:0]           state_q, state_d;
    logic [1:0]           layer_q, layer_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0] win_cnt_q, win_cnt_d;
    logic                 busy_q, busy_d;
    logic                 slide_q, slide_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [1:0]            tag_layer_q [RD_LATENCY];
    logic [1:0]            tag_layer_d [RD_LATENCY];
    logic [IDX_WIDTH-1:0]  tag_idx_q   [RD_LATENCY];
    logic [IDX_WIDTH-1:0]  tag_idx_d   [RD_LATENCY];

    logic                      w_ren;
    logic                      w_pipe_busy;
    logic [MEM_ADDR_WIDTH-1:0] w_base;
    logic [IDX_WIDTH-1:0]      w_last;
    logic [CNT_WIDTH-1:0]      w_win_next;

    always_comb begin
        w_base = '0;
        w_last = c_last_l1;
        case (layer_q)
            2'd2:    begin w_base = c_base_l2; w_last = c_last_l2; end
            2'd3:    begin w_base = c_base_l3; w_last = c_last_l3; end
            default: begin w_base = '0;        w_last = c_last_l1; end
        endcase

        w_ren      = (state_q == c_st_fetch) && bus.calc_ready;
        w_win_next = (win_cnt_q == c_num_win) ? win_cnt_q : win_cnt_q + CNT_WIDTH'(1);

        // The output stage may still hold a row; only earlier stages keep DRAIN alive.
        w_pipe_busy = 1'b0;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            w_pipe_busy = w_pipe_busy | vld_q[i];
        end

        vld_d          = '0;
        vld_d[0]       = w_ren;
        tag_layer_d[0] = w_ren ? layer_q : 2'd0;
        tag_idx_d[0]   = w_ren ? idx_q : '0;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]       = vld_q[i-1];
            tag_layer_d[i] = tag_layer_q[i-1];
            tag_idx_d[i]   = tag_idx_q[i-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        idx_d     = idx_q;
        win_cnt_d = win_cnt_q;
        busy_d    = busy_q;
        slide_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            c_st_idle: begin
                if (bus.start) begin
                    state_d   = c_st_wait_win;
                    busy_d    = 1'b1;
                    win_cnt_d = '0;
                    layer_d   = 2'd1;
                    idx_d     = '0;
                    err_d     = 1'b0;
                end
            end
            c_st_wait_win: begin
                if (bus.win_valid) begin
                    state_d = c_st_fetch;
                    idx_d   = '0;
                end
            end
            c_st_fetch: begin
                if (w_ren) begin
                    if (idx_q == w_last) begin
                        state_d = c_st_drain;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            c_st_drain: begin
                if (!w_pipe_busy) begin
                    state_d = c_st_wait_calc;
                end
            end
            c_st_wait_calc: begin
                if (bus.calc_layer_done) begin
                    if (layer_q != 2'd3) begin
                        layer_d = layer_q + 2'd1;
                        idx_d   = '0;
                        state_d = c_st_fetch;
                    end else begin
                        slide_d = 1'b1;
                        state_d = c_st_next_win;
                    end
                end
            end
            c_st_next_win: begin
                win_cnt_d = w_win_next;
                if (w_win_next == c_num_win) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    layer_d = 2'd0;
                    state_d = c_st_idle;
                end else begin
                    layer_d = 2'd1;
                    state_d = c_st_wait_win;
                end
            end
            default: state_d = c_st_idle;
        endcase

        // Layer-done is only legal once every row of the layer has been delivered.
        if (bus.calc_layer_done && (state_q != c_st_wait_calc)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_st_idle;
            layer_q   <= 2'd0;
            idx_q     <= '0;
            win_cnt_q <= '0;
            busy_q    <= 1'b0;
            slide_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            vld_q     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_layer_q[i] <= 2'd0;
                tag_idx_q[i]   <= '0;
            end
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            idx_q     <= idx_d;
            win_cnt_q <= win_cnt_d;
            busy_q    <= busy_d;
            slide_q   <= slide_d;
            done_q    <= done_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_layer_q[i] <= tag_layer_d[i];
                tag_idx_q[i]   <= tag_idx_d[i];
            end
        end
    end

    assign bus.mem_ren   = w_ren;
    assign bus.mem_addr  = (state_q == c_st_fetch) ? (w_base + MEM_ADDR_WIDTH'(idx_q)) : '0;
    assign bus.row_valid = vld_q[RD_LATENCY-1];
    assign bus.row_layer = tag_layer_q[RD_LATENCY-1];
    assign bus.row_idx   = tag_idx_q[RD_LATENCY-1];
    assign bus.slide     = slide_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] busy_cnt_q, busy_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        busy_cnt_d  = busy_cnt_q;
        if ((state_q == c_st_idle) && bus.start) begin
            stall_cnt_d = '0;
            busy_cnt_d  = '0;
        end else begin
            if ((state_q == c_st_fetch) && !bus.calc_ready && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (busy_q && (busy_cnt_q != '1)) begin
                busy_cnt_d = busy_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            busy_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign busy_cycles  = busy_cnt_q;
`endif
endmodule
`default_nettype wire
